scope_trig_event_pio: RTL and testbench

- Avalon-MM slave input PIO in the scope SOPC system. It is the receive direction, complementing the CPU-written output PIO registers such as the trigger-period register.
- Samples WIDTH asynchronous status/event lines from scope logic (trigger fired, capture done, FIFO overrun, ...) and synchronizes them.
- Latches selected edges into a sticky edge-capture register, with per-bit IRQ masking.
- Counts events on one designated bit so firmware can measure trigger rate.

---
 rtl/scope_pio_pkg.sv | 18 +
 rtl/scope_sync_edge.sv | 47 ++++
 rtl/scope_trig_event_pio.sv | 104 ++++++++++
 tb/tb_scope_trig_event_pio.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/scope_pio_pkg.sv
// Shared definitions for the scope event-input PIO: register map and edge encodings.
package scope_pio_pkg;

  // Avalon word addresses of the four registers.
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
  localparam logic [1:0] ADDR_EVT_CNT  = 2'd3;

  // Encodings of the EDGE_TYPE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Saturation ceiling of the event counter.
  localparam logic [31:0] EVT_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/scope_sync_edge.sv
// Per-line synchronizer chain, one-clock history register and edge detector.
module scope_sync_edge
  import scope_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Shift the asynchronous inputs through the synchronizer and keep last cycle's value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every synchronizer stage is cleared, not just the last one, so no
      // stale level can ripple out as a fake edge after reset is released.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Select the configured edge polarity from the synchronized value and its history.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves edge_det
    // unassigned, which would otherwise infer a latch.
    edge_det = sync_out ^ prev_q;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = sync_out & ~prev_q;
      EDGE_FALL: edge_det = ~sync_out & prev_q;
      default:   edge_det = sync_out ^ prev_q;
    endcase
  end

endmodule

// File: rtl/scope_trig_event_pio.sv
// Avalon-MM input PIO: synchronized status lines, sticky edge capture with
// masked level IRQ, and a saturating event counter on one designated line.
module scope_trig_event_pio
  import scope_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_BIT   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Edge detection stays blind until the synchronizer and history hold real samples.
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_gated;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      evt_cnt;
  logic [31:0]      evt_cnt_nxt;
  logic [2:0]       warm_cnt;
  logic             warm_done;
  logic             wr_en;
  logic             unused_wdata;

  scope_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_out (sync_out),
    .edge_det (edge_det)
  );

  assign wr_en      = chipselect && !write_n;
  assign warm_done  = (warm_cnt == WARM_LAST);
  assign edge_gated = warm_done ? edge_det : '0;
  assign clr_mask   = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  // Writedata bits above WIDTH have no register behind them.
  assign unused_wdata = &{1'b0, writedata};

  // Count clocks after reset release until edge detection is trusted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
  end

  // IRQ mask register, written from the low WIDTH bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               irq_mask <= '0;
    else if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
  end

  // Sticky edge capture; a fresh edge beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~clr_mask) | edge_gated;
  end

  // Next event count: any write clears, increment saturates at all-ones.
  always_comb begin
    evt_cnt_nxt = evt_cnt;
    if (wr_en && address == ADDR_EVT_CNT)
      evt_cnt_nxt = edge_gated[COUNT_BIT] ? 32'd1 : 32'd0;
    else if (edge_gated[COUNT_BIT] && evt_cnt != EVT_CNT_MAX)
      evt_cnt_nxt = evt_cnt + 32'd1;
  end

  // Event counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) evt_cnt <= '0;
    else          evt_cnt <= evt_cnt_nxt;
  end

  // Zero-wait-state read mux straight from the registers.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(sync_out);
      ADDR_IRQ_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE_CAP: readdata = 32'(edge_cap);
      default:       readdata = evt_cnt;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_scope_trig_event_pio.sv
// Directed bench: a rising-edge instance and an any-edge instance on one shared bus.
module tb_scope_trig_event_pio;
  import scope_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [31:0] readdata_b;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  in_port_b = 8'h00;
  logic        irq;
  logic        irq_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scope_trig_event_pio #(
    .WIDTH(8), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2), .COUNT_BIT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  scope_trig_event_pio #(
    .WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2), .COUNT_BIT(1)
  ) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .in_port(in_port_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic chk_reg_b(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata_b, exp);
  endtask

  initial begin
    // 1: release reset with all lines high; no rising capture may appear.
    in_port = 8'hFF;
    #22 reset_n = 1'b1;
    wait_n(10);
    chk_reg("t1_data", ADDR_DATA, 32'h0000_00FF);
    chk_reg("t1_edge_cap", ADDR_EDGE_CAP, 32'h0);
    check("t1_irq", {31'd0, irq}, 32'h0);
    chk_reg("t1_evt_cnt", ADDR_EVT_CNT, 32'h0);

    // 2: falling edges are ignored, then a rising edge on bit 3 with latency checks.
    in_port = 8'h00;
    wait_n(5);
    chk_reg("t2_fall_ignored", ADDR_EDGE_CAP, 32'h0);
    in_port = 8'h08;
    @(negedge clk);
    chk_reg("t2_data_edge_k", ADDR_DATA, 32'h0);
    @(negedge clk);
    chk_reg("t2_data_edge_k1", ADDR_DATA, 32'h08);
    chk_reg("t2_cap_edge_k1", ADDR_EDGE_CAP, 32'h0);
    @(negedge clk);
    chk_reg("t2_cap_edge_k2", ADDR_EDGE_CAP, 32'h08);
    check("t2_irq_masked", {31'd0, irq}, 32'h0);
    wr(ADDR_IRQ_MASK, 32'hFFFF_FF08);
    check("t2_irq_unmasked", {31'd0, irq}, 32'h1);
    chk_reg("t2_mask_read", ADDR_IRQ_MASK, 32'h08);
    wr(ADDR_EDGE_CAP, 32'h08);
    check("t2_irq_cleared", {31'd0, irq}, 32'h0);
    chk_reg("t2_cap_cleared", ADDR_EDGE_CAP, 32'h0);

    // 3: W1C of bit 2 lands in the cycle its edge is detected; the edge wins.
    in_port = 8'h0C;
    @(negedge clk);
    @(negedge clk);
    wr(ADDR_EDGE_CAP, 32'h04);
    chk_reg("t3_edge_beats_clr", ADDR_EDGE_CAP, 32'h04);
    wr(ADDR_EDGE_CAP, 32'h00);
    chk_reg("t3_zero_write", ADDR_EDGE_CAP, 32'h04);
    chk_reg("t3_data_write_ignored", ADDR_DATA, 32'h0C);
    wr(ADDR_EDGE_CAP, 32'h04);
    chk_reg("t3_cap_cleared", ADDR_EDGE_CAP, 32'h0);

    // 4: five rising pulses on bit 0, then a clear coincident with a sixth edge.
    for (int i = 0; i < 5; i++) begin
      in_port[0] = 1'b1;
      wait_n(3);
      in_port[0] = 1'b0;
      wait_n(3);
    end
    chk_reg("t4_count5", ADDR_EVT_CNT, 32'd5);
    in_port[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(ADDR_EVT_CNT, 32'h0);
    chk_reg("t4_clr_and_inc", ADDR_EVT_CNT, 32'd1);
    wait_n(4);
    chk_reg("t4_count_held", ADDR_EVT_CNT, 32'd1);
    wr(ADDR_EVT_CNT, 32'h1234_5678);
    chk_reg("t4_clr_alone", ADDR_EVT_CNT, 32'd0);

    // 5: any-edge instance captures both edges of one pulse; counter saturates.
    in_port_b = 8'h02;
    wait_n(3);
    chk_reg_b("t5_rise_cap", ADDR_EDGE_CAP, 32'h02);
    chk_reg_b("t5_rise_cnt", ADDR_EVT_CNT, 32'd1);
    wr(ADDR_EDGE_CAP, 32'h02);
    chk_reg_b("t5_cap_cleared", ADDR_EDGE_CAP, 32'h0);
    in_port_b = 8'h00;
    wait_n(3);
    chk_reg_b("t5_fall_cap", ADDR_EDGE_CAP, 32'h02);
    chk_reg_b("t5_fall_cnt", ADDR_EVT_CNT, 32'd2);
    force dut_any.evt_cnt = 32'hFFFF_FFFE;
    #1;
    release dut_any.evt_cnt;
    @(negedge clk);
    in_port_b = 8'h02;
    wait_n(3);
    chk_reg_b("t5_reach_max", ADDR_EVT_CNT, 32'hFFFF_FFFF);
    in_port_b = 8'h00;
    wait_n(3);
    chk_reg_b("t5_saturate", ADDR_EVT_CNT, 32'hFFFF_FFFF);

    // 6: reach irq=1 and count 7, then reset mid-stream with lines held high.
    for (int i = 0; i < 7; i++) begin
      in_port[0] = 1'b0;
      in_port[3] = 1'b0;
      wait_n(3);
      in_port[0] = 1'b1;
      wait_n(3);
    end
    in_port[3] = 1'b1;
    wait_n(3);
    chk_reg("t6_count7", ADDR_EVT_CNT, 32'd7);
    check("t6_irq_high", {31'd0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_irq_async_drop", {31'd0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      chk_reg($sformatf("t6_in_reset_addr%0d", a), 2'(a), 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_n(10);
    chk_reg("t6_data_after", ADDR_DATA, 32'h0D);
    chk_reg("t6_mask_after", ADDR_IRQ_MASK, 32'h0);
    chk_reg("t6_cap_after", ADDR_EDGE_CAP, 32'h0);
    chk_reg("t6_cnt_after", ADDR_EVT_CNT, 32'h0);
    check("t6_irq_after", {31'd0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
